// File: rtl/io_port_hub.sv
// MCU port hub: addressed output registers, input channel read mux and a small
// interrupt controller (pending/mask/vector/mode CSRs) behind one 8-bit port bus.
module io_port_hub #(
  parameter int         N_OUT    = 4,
  parameter int         N_IN     = 4,
  parameter int         N_IRQ    = 4,
  parameter logic [7:0] BASE_OUT = 8'h40,
  parameter logic [7:0] BASE_IN  = 8'h20,
  parameter logic [7:0] CSR_BASE = 8'hF0
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic [7:0]         PORT_ID,
  input  logic [7:0]         OUT_PORT,
  input  logic               IO_STRB,
  output logic [7:0]         IN_PORT,
  input  logic [8*N_IN-1:0]  IN_DATA,
  output logic [8*N_OUT-1:0] OUT_DATA,
  input  logic [N_IRQ-1:0]   IRQ_SRC,
  output logic               INTERRUPT
);

  localparam logic [7:0] N_OUT_B = 8'(N_OUT);
  localparam logic [7:0] N_IN_B  = 8'(N_IN);

  function automatic logic [7:0] widen(input logic [N_IRQ-1:0] v);
    logic [7:0] r;
    r = '0;
    r[N_IRQ-1:0] = v;
    return r;
  endfunction

  function automatic logic [7:0] lowest_set(input logic [N_IRQ-1:0] v);
    logic [7:0] r;
    r = 8'hFF;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (v[i]) r = 8'(i);
    end
    return r;
  endfunction

  logic [8*N_OUT-1:0] out_q, out_d;
  logic [N_IRQ-1:0]   sync1_q, sync2_q, prev_q;
  logic [N_IRQ-1:0]   pend_q, pend_d;
  logic [N_IRQ-1:0]   mask_q, mask_d;
  logic [N_IRQ-1:0]   mode_q, mode_d;
  logic               int_q, int_d;
  logic [1:0]         arm_q, arm_d;

  logic [7:0]       off_out, off_in, off_csr;
  logic             csr_hit, in_hit, out_hit;
  logic             csr_wr, out_wr;
  logic             armed;
  logic [N_IRQ-1:0] edge_ev, set_ev, clr;

  assign off_out = PORT_ID - BASE_OUT;
  assign off_in  = PORT_ID - BASE_IN;
  assign off_csr = PORT_ID - CSR_BASE;

  assign csr_hit = (off_csr < 8'd4);
  assign in_hit  = (off_in < N_IN_B);
  assign out_hit = (off_out < N_OUT_B);

  assign csr_wr = IO_STRB & csr_hit;
  assign out_wr = IO_STRB & out_hit & ~csr_hit;

  // Edge detection stays disarmed until the synchronizer and previous-value
  // flops have refilled after reset, so a line held high through reset is not
  // mistaken for a fresh rising edge.
  assign armed   = (arm_q == 2'd3);
  assign edge_ev = sync2_q & ~prev_q & {N_IRQ{armed}};
  assign set_ev  = (mode_q & edge_ev) | (~mode_q & sync2_q);
  assign clr     = (csr_wr && off_csr == 8'd0) ? OUT_PORT[N_IRQ-1:0] : '0;

  always_comb begin
    out_d  = out_q;
    mask_d = mask_q;
    mode_d = mode_q;
    arm_d  = armed ? arm_q : arm_q + 2'd1;
    pend_d = (pend_q & ~clr) | set_ev;
    int_d  = |(pend_q & mask_q);
    if (out_wr) begin
      for (int k = 0; k < N_OUT; k++) begin
        if (off_out == 8'(k)) out_d[8*k +: 8] = OUT_PORT;
      end
    end
    if (csr_wr && off_csr == 8'd1) mask_d = OUT_PORT[N_IRQ-1:0];
    if (csr_wr && off_csr == 8'd3) mode_d = OUT_PORT[N_IRQ-1:0];
  end

  always_comb begin
    IN_PORT = 8'h00;
    if (csr_hit) begin
      case (off_csr[1:0])
        2'd0:    IN_PORT = widen(pend_q);
        2'd1:    IN_PORT = widen(mask_q);
        2'd2:    IN_PORT = lowest_set(pend_q & mask_q);
        default: IN_PORT = widen(mode_q);
      endcase
    end else if (in_hit) begin
      for (int k = 0; k < N_IN; k++) begin
        if (off_in == 8'(k)) IN_PORT = IN_DATA[8*k +: 8];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      out_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      mode_q  <= '1;
      int_q   <= 1'b0;
      arm_q   <= 2'd0;
    end else begin
      out_q   <= out_d;
      sync1_q <= IRQ_SRC;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      int_q   <= int_d;
      arm_q   <= arm_d;
    end
  end

  assign OUT_DATA  = out_q;
  assign INTERRUPT = int_q;

endmodule

// File: tb/tb_io_port_hub.sv
// Directed bench for io_port_hub: table of port read/write vectors, then
// hand-timed interrupt sequences around edge/level modes and reset.
module tb_io_port_hub;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [7:0]  PORT_ID;
  logic [7:0]  OUT_PORT;
  logic        IO_STRB;
  logic [7:0]  IN_PORT;
  logic [31:0] IN_DATA;
  logic [31:0] OUT_DATA;
  logic [3:0]  IRQ_SRC;
  logic        INTERRUPT;

  int checks   = 0;
  int failures = 0;

  io_port_hub dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .PORT_ID  (PORT_ID),
    .OUT_PORT (OUT_PORT),
    .IO_STRB  (IO_STRB),
    .IN_PORT  (IN_PORT),
    .IN_DATA  (IN_DATA),
    .OUT_DATA (OUT_DATA),
    .IRQ_SRC  (IRQ_SRC),
    .INTERRUPT(INTERRUPT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]  pid;
    logic [7:0]  wd;
    logic        strb;
    logic [7:0]  rd;
    logic [31:0] od;
  } vec_t;

  vec_t vt[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  task automatic wr(input logic [7:0] pid, input logic [7:0] d);
    PORT_ID  = pid;
    OUT_PORT = d;
    IO_STRB  = 1'b1;
    @(negedge CLK);
    IO_STRB  = 1'b0;
  endtask

  task automatic rd(input logic [7:0] pid, input logic [7:0] exp, input string name);
    PORT_ID = pid;
    IO_STRB = 1'b0;
    #1;
    chk(name, {24'h0, IN_PORT}, {24'h0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vt[0]  = '{8'h22, 8'h00, 1'b0, 8'h3C, 32'h0000_0000};
    vt[1]  = '{8'h41, 8'hA5, 1'b1, 8'h00, 32'h0000_A500};
    vt[2]  = '{8'h30, 8'h00, 1'b0, 8'h00, 32'h0000_A500};
    vt[3]  = '{8'h20, 8'h00, 1'b0, 8'h11, 32'h0000_A500};
    vt[4]  = '{8'h23, 8'h00, 1'b0, 8'h44, 32'h0000_A500};
    vt[5]  = '{8'h24, 8'h00, 1'b0, 8'h00, 32'h0000_A500};
    vt[6]  = '{8'h43, 8'h77, 1'b1, 8'h00, 32'h7700_A500};
    vt[7]  = '{8'h44, 8'h99, 1'b1, 8'h00, 32'h7700_A500};
    vt[8]  = '{8'h40, 8'h12, 1'b0, 8'h00, 32'h7700_A500};
    vt[9]  = '{8'h40, 8'h5A, 1'b1, 8'h00, 32'h7700_A55A};
    vt[10] = '{8'hF3, 8'h00, 1'b0, 8'h0F, 32'h7700_A55A};
    vt[11] = '{8'hF2, 8'h00, 1'b0, 8'hFF, 32'h7700_A55A};
    vt[12] = '{8'hF0, 8'h00, 1'b0, 8'h00, 32'h7700_A55A};
    vt[13] = '{8'hF1, 8'h00, 1'b0, 8'h00, 32'h7700_A55A};
    vt[14] = '{8'hF4, 8'hFF, 1'b1, 8'h00, 32'h7700_A55A};
    vt[15] = '{8'h3F, 8'h55, 1'b1, 8'h00, 32'h7700_A55A};
    vt[16] = '{8'h1F, 8'h00, 1'b0, 8'h00, 32'h7700_A55A};
    vt[17] = '{8'h21, 8'h00, 1'b0, 8'h22, 32'h7700_A55A};

    RESET_N  = 1'b0;
    PORT_ID  = 8'h00;
    OUT_PORT = 8'h00;
    IO_STRB  = 1'b0;
    IN_DATA  = 32'h443C_2211;
    IRQ_SRC  = 4'h0;
    steps(3);
    chk("rst_out", OUT_DATA, 32'h0);
    chk("rst_int", {31'h0, INTERRUPT}, 32'h0);
    rd(8'hF3, 8'h0F, "rst_mode");
    RESET_N = 1'b1;
    steps(4);

    for (int i = 0; i < 18; i++) begin
      PORT_ID  = vt[i].pid;
      OUT_PORT = vt[i].wd;
      IO_STRB  = vt[i].strb;
      #1;
      chk($sformatf("vec%0d_rd", i), {24'h0, IN_PORT}, {24'h0, vt[i].rd});
      step();
      IO_STRB = 1'b0;
      chk($sformatf("vec%0d_out", i), OUT_DATA, vt[i].od);
    end

    // Masked edge event, vector, clear and interrupt lag
    wr(8'hF1, 8'h04);
    IRQ_SRC = 4'b0100;
    step();
    IRQ_SRC = 4'b0000;
    step();
    rd(8'hF0, 8'h00, "pend_early");
    step();
    rd(8'hF0, 8'h04, "pend_edge2");
    chk("int_not_yet", {31'h0, INTERRUPT}, 32'h0);
    step();
    chk("int_edge3", {31'h0, INTERRUPT}, 32'h1);
    rd(8'hF2, 8'h02, "vector2");
    wr(8'hF0, 8'h04);
    rd(8'hF0, 8'h00, "w1c_bit2");
    chk("int_lag", {31'h0, INTERRUPT}, 32'h1);
    step();
    chk("int_cleared", {31'h0, INTERRUPT}, 32'h0);

    // Pending recorded while masked; unmasking raises INTERRUPT one edge later
    wr(8'hF1, 8'h00);
    IRQ_SRC = 4'b0010;
    step();
    IRQ_SRC = 4'b0000;
    steps(2);
    rd(8'hF0, 8'h02, "pend_masked");
    step();
    chk("int_masked", {31'h0, INTERRUPT}, 32'h0);
    rd(8'hF2, 8'hFF, "vector_none");
    wr(8'hF1, 8'h02);
    chk("int_unmask0", {31'h0, INTERRUPT}, 32'h0);
    step();
    chk("int_unmask1", {31'h0, INTERRUPT}, 32'h1);
    rd(8'hF2, 8'h01, "vector1");
    wr(8'hF0, 8'h02);
    wr(8'hF1, 8'h00);
    step();
    chk("int_off", {31'h0, INTERRUPT}, 32'h0);

    // Level mode on bit 0; coincident set and clear on bit 3
    wr(8'hF3, 8'h0E);
    IRQ_SRC = 4'b0001;
    steps(3);
    rd(8'hF0, 8'h01, "lvl_pend");
    wr(8'hF0, 8'h01);
    rd(8'hF0, 8'h01, "lvl_w1c_sticky");
    IRQ_SRC = 4'b1001;
    steps(2);
    wr(8'hF0, 8'h08);
    rd(8'hF0, 8'h09, "set_wins");
    IRQ_SRC = 4'b0000;
    steps(3);
    wr(8'hF0, 8'h0F);
    rd(8'hF0, 8'h00, "w1c_clears");
    wr(8'hF3, 8'h0F);

    // Held source in edge mode, then switch to level
    IRQ_SRC = 4'b0010;
    steps(4);
    rd(8'hF0, 8'h02, "edge_held");
    wr(8'hF0, 8'h02);
    rd(8'hF0, 8'h00, "edge_held_noset");
    wr(8'hF3, 8'h0D);
    rd(8'hF0, 8'h00, "mode_wr_keeps_pend");
    step();
    rd(8'hF0, 8'h02, "lvl_switch_set");
    IRQ_SRC = 4'b0000;
    steps(3);
    wr(8'hF3, 8'h0F);
    wr(8'hF0, 8'h0F);
    rd(8'hF0, 8'h00, "pend_idle");

    // Reset with state present and a simultaneous write
    wr(8'hF1, 8'h0F);
    IRQ_SRC = 4'b1111;
    step();
    IRQ_SRC = 4'b0000;
    steps(2);
    rd(8'hF0, 8'h0F, "pend_all");
    step();
    chk("int_all", {31'h0, INTERRUPT}, 32'h1);
    PORT_ID  = 8'h42;
    OUT_PORT = 8'hFF;
    IO_STRB  = 1'b1;
    IRQ_SRC  = 4'b0100;
    RESET_N  = 1'b0;
    step();
    IO_STRB = 1'b0;
    chk("rst2_out", OUT_DATA, 32'h0);
    chk("rst2_int", {31'h0, INTERRUPT}, 32'h0);
    rd(8'hF0, 8'h00, "rst2_pend");
    rd(8'hF1, 8'h00, "rst2_mask");
    rd(8'hF3, 8'h0F, "rst2_mode");
    rd(8'hF2, 8'hFF, "rst2_vector");
    step();
    RESET_N = 1'b1;
    steps(6);
    wr(8'hF1, 8'h04);
    rd(8'hF0, 8'h00, "held_thru_rst");
    step();
    chk("held_thru_rst_int", {31'h0, INTERRUPT}, 32'h0);
    IRQ_SRC = 4'b0000;
    steps(3);
    IRQ_SRC = 4'b0100;
    step();
    IRQ_SRC = 4'b0000;
    steps(2);
    rd(8'hF0, 8'h04, "post_rst_edge");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/io_port_hub.md
IO_PORT_HUB -- requirements
Module: io_port_hub

Interface
REQ-001 The block SHALL accept parameter N_OUT, default 4: number of 8-bit output registers, 1..16.
REQ-002 The block SHALL accept parameter N_IN, default 4: number of 8-bit input channels, 1..16.
REQ-003 The block SHALL accept parameter N_IRQ, default 4: number of interrupt sources, 1..8.
REQ-004 The block SHALL accept parameters BASE_OUT (8'h40), BASE_IN (8'h20) and CSR_BASE (8'hF0): first port ID of each region.
REQ-005 CLK  input  1  sole clock; all state changes on its rising edge.
REQ-006 RESET_N  input  1  synchronous, active-low reset.
REQ-007 PORT_ID  input  8  MCU port address.
REQ-008 OUT_PORT  input  8  MCU write data.
REQ-009 IO_STRB  input  1  MCU write strobe; one-cycle write qualifier.
REQ-010 IN_PORT  output  8  combinational read data to the MCU.
REQ-011 IN_DATA  input  8*N_IN  input channels; channel k in bits [8k+7:8k].
REQ-012 OUT_DATA  output  8*N_OUT  output registers; register k in bits [8k+7:8k].
REQ-013 IRQ_SRC  input  N_IRQ  asynchronous interrupt request lines.
REQ-014 INTERRUPT  output  1  registered interrupt request to the MCU.

Function
REQ-015 IO_STRB=1 with PORT_ID=BASE_OUT+k (k<N_OUT) SHALL load OUT_PORT into register k at that edge; other registers hold.
REQ-016 PORT_ID=BASE_IN+k (k<N_IN) SHALL drive IN_PORT=channel k combinationally.
REQ-017 CSR map: CSR_BASE+0 PENDING (read; write-1-to-clear), +1 MASK (r/w), +2 VECTOR (read-only), +3 MODE (r/w; bit=1 edge, 0 level); bits at and above N_IRQ SHALL read 0 and ignore writes.
REQ-018 CSR decode SHALL take priority over input/output decode; unmapped PORT_ID SHALL read 8'h00 and writes to it SHALL be ignored.
REQ-019 Each IRQ_SRC bit SHALL pass through a two-flop synchronizer, then a registered previous-value flop for edge detection.
REQ-020 Edge mode: a synchronized 0->1 transition SHALL set the PENDING bit; IRQ_SRC high at edge k -> PENDING bit 1 after edge k+2.
REQ-021 Level mode: PENDING bit SHALL be set every cycle the synchronized source is 1; write-1-to-clear has no lasting effect while it stays high.
REQ-022 Same-cycle set and write-1-to-clear on one bit: set SHALL win (bit stays 1).
REQ-023 PENDING SHALL record events regardless of MASK.
REQ-024 INTERRUPT SHALL be a register loaded each edge with OR(PENDING & MASK), i.e. one cycle after the PENDING/MASK change.
REQ-025 VECTOR SHALL read the lowest index i with PENDING[i]&MASK[i]=1, zero-extended; 8'hFF when none.
REQ-026 Writing MODE SHALL NOT alter PENDING; switching edge->level with the source high SHALL set PENDING next edge.
REQ-027 Read has no side effects; only IO_STRB writes change CSRs.

Reset
REQ-028 RESET_N=0 at an edge SHALL clear all output registers, PENDING, MASK, synchronizer and edge flops, and INTERRUPT to 0, and set MODE to all-ones (edge).
REQ-029 Reset SHALL take priority over a simultaneous IO_STRB write or interrupt event.
REQ-030 Events within two edges after reset release MAY be lost; a source held high through reset release in edge mode SHALL NOT set PENDING.

Verification
REQ-031 Write 8'hA5 to 8'h41, then read 8'h41 region via OUT_DATA -> OUT_DATA[15:8]=8'hA5, other registers 8'h00.
REQ-032 IN_DATA channel 2=8'h3C, PORT_ID=8'h22 -> IN_PORT=8'h3C; PORT_ID=8'h30 -> 8'h00.
REQ-033 MASK=8'h04, pulse IRQ_SRC[2] at edge k -> PENDING=8'h04 after k+2, INTERRUPT=1 after k+3, VECTOR=8'h02; write 8'h04 to CSR_BASE -> INTERRUPT=0 one edge after PENDING clears.
REQ-034 MASK=0, pulse IRQ_SRC[1] -> PENDING=8'h02, INTERRUPT stays 0, VECTOR=8'hFF; then MASK=8'h02 -> INTERRUPT=1 next edge.
REQ-035 Level mode bit 0, source held high, write-1-to-clear -> PENDING[0] still 1; new edge on bit 3 coincident with clear of bit 3 -> PENDING[3]=1.
REQ-036 RESET_N=0 with PENDING=8'h0F and OUT_DATA nonzero -> all zero, MODE=8'h0F, INTERRUPT=0 after that edge.
